// File: rtl/elastic_pipe.sv
// Elastic register pipeline: WIDTH-bit words through DEPTH valid-tagged stages with a
// valid/ready handshake, per-stage backpressure, bubble collapsing, flush and occupancy count.
module elastic_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CW-1:0]    count
);

    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [CW-1:0]    r_count;

    logic [DEPTH-1:0] w_adv;
    logic             w_in_fire;
    logic             w_out_fire;
    logic [CW-1:0]    w_count_d;

    // A stage may move when it is empty or everything downstream of it moves.
    always_comb begin
        w_adv            = '0;
        w_adv[DEPTH-1]   = !r_valid[DEPTH-1] || out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            w_adv[i] = !r_valid[i] || w_adv[i+1];
        end
    end

    assign in_ready   = w_adv[0] && !flush;
    assign out_valid  = r_valid[DEPTH-1];
    assign out_data   = r_data[DEPTH-1];
    assign count      = r_count;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    always_comb begin
        w_count_d = r_count;
        unique case ({w_in_fire, w_out_fire})
            2'b10:   w_count_d = r_count + CW'(1);
            2'b01:   w_count_d = r_count - CW'(1);
            default: w_count_d = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else if (flush) begin
            // Data registers are left alone; only the valid tags are dropped.
            r_valid <= '0;
            r_count <= '0;
        end else begin
            if (w_adv[0]) begin
                r_valid[0] <= w_in_fire;
                if (w_in_fire) begin
                    r_data[0] <= in_data;
                end
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_adv[i]) begin
                    r_valid[i] <= r_valid[i-1];
                    if (r_valid[i-1]) begin
                        r_data[i] <= r_data[i-1];
                    end
                end
            end
            r_count <= w_count_d;
        end
    end

endmodule

// File: tb/tb_elastic_pipe.sv
// Self-checking bench for elastic_pipe: directed scenarios plus randomized traffic checked
// against a queue-of-words model that tracks each word's position in the pipe.
module tb_elastic_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready = 1'b0;
    logic [CW-1:0]    count;

    int n_checks = 0;
    int n_errors = 0;

    elastic_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .count    (count)
    );

    always #5 clk = ~clk;

    // Reference model: words in acceptance order, each with its stage position.
    logic [WIDTH-1:0] mq_data [$];
    int               mq_pos [$];
    int               t_pos [$];
    bit               t_pop;
    logic [WIDTH-1:0] m_last = '0;

    // Front word leaves if at the end and taken; every other word steps forward unless it
    // would land on the word ahead of it.
    function automatic void m_move(input bit ordy);
        int lim;
        int np;
        int first;
        t_pop = (mq_pos.size() > 0) && (mq_pos[0] == DEPTH - 1) && ordy;
        t_pos.delete();
        lim   = DEPTH - 1;
        first = t_pop ? 1 : 0;
        for (int i = first; i < mq_pos.size(); i++) begin
            np = mq_pos[i] + 1;
            if (np > lim) np = lim;
            t_pos.push_back(np);
            lim = np - 1;
        end
    endfunction

    function automatic bit m_in_ready(input bit fl, input bit ordy);
        if (fl) return 1'b0;
        m_move(ordy);
        if (t_pos.size() == 0) return 1'b1;
        return t_pos[t_pos.size() - 1] >= 1;
    endfunction

    function automatic bit m_out_valid();
        return (mq_pos.size() > 0) && (mq_pos[0] == DEPTH - 1);
    endfunction

    function automatic void m_tick();
        bit acc;
        if (rst) begin
            mq_data.delete();
            mq_pos.delete();
            m_last = '0;
        end else if (flush) begin
            mq_data.delete();
            mq_pos.delete();
        end else begin
            acc = in_valid && m_in_ready(1'b0, out_ready);
            m_move(out_ready);
            if (t_pop) void'(mq_data.pop_front());
            mq_pos = t_pos;
            if (acc) begin
                mq_data.push_back(in_data);
                mq_pos.push_back(0);
            end
            if (mq_pos.size() > 0 && mq_pos[0] == DEPTH - 1) m_last = mq_data[0];
        end
    endfunction

    task automatic tick();
        m_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 20; c++) begin
            rst       = 1'b0;
            flush     = 1'b0;
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = WIDTH'($urandom);
            out_ready = ($urandom_range(0, 3) == 0);
            #1;
            tick();
        end
        rst      = 1'b1;
        in_valid = 1'b1;
        tick();
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        n_checks++;
        if (out_data !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_out_data got=%h want=00", out_data);
        end
        n_checks++;
        if (count !== 0) begin
            n_errors++;
            $display("FAIL reset_count got=%0d want=0", count);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_stream();
        int exp_cnt;
        bit exp_v;
        for (int c = 0; c < 14; c++) begin
            out_ready = 1'b1;
            flush     = 1'b0;
            in_valid  = (c < 8);
            in_data   = WIDTH'(c + 1);
            #1;
            exp_v   = (c >= 4) && (c <= 11);
            exp_cnt = ((c < 8) ? c : 8) - ((c < 4) ? 0 : ((c - 4 > 8) ? 8 : c - 4));
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL stream_in_ready c=%0d got=%b want=1", c, in_ready);
            end
            n_checks++;
            if (out_valid !== exp_v) begin
                n_errors++;
                $display("FAIL stream_out_valid c=%0d got=%b want=%b", c, out_valid, exp_v);
            end
            if (exp_v) begin
                n_checks++;
                if (out_data !== WIDTH'(c - 3)) begin
                    n_errors++;
                    $display("FAIL stream_out_data c=%0d got=%h want=%h", c, out_data, c - 3);
                end
            end
            n_checks++;
            if (count !== CW'(exp_cnt)) begin
                n_errors++;
                $display("FAIL stream_count c=%0d got=%0d want=%0d", c, count, exp_cnt);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int nout = 0;
        for (int c = 0; c < 8; c++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = WIDTH'(8'h10 + acc);
            #1;
            n_checks++;
            if (in_ready !== (c < 4)) begin
                n_errors++;
                $display("FAIL bp_in_ready c=%0d got=%b want=%b", c, in_ready, c < 4);
            end
            if (in_ready) acc++;
            tick();
        end
        n_checks++;
        if (count !== CW'(4) || acc != 4) begin
            n_errors++;
            $display("FAIL bp_full count=%0d accepted=%0d want=4/4", count, acc);
        end
        for (int r = 0; r < 12; r++) begin
            out_ready = 1'b1;
            in_valid  = (acc < 6);
            in_data   = WIDTH'(8'h10 + acc);
            #1;
            if (r < 3) begin
                n_checks++;
                if (count !== CW'(4)) begin
                    n_errors++;
                    $display("FAIL bp_count_full r=%0d got=%0d want=4", r, count);
                end
            end
            if (in_valid) begin
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_errors++;
                    $display("FAIL bp_in_ready_release r=%0d got=%b want=1", r, in_ready);
                end
            end
            if (out_valid) begin
                n_checks++;
                if (out_data !== WIDTH'(8'h10 + nout)) begin
                    n_errors++;
                    $display("FAIL bp_order r=%0d got=%h want=%h", r, out_data, 8'h10 + nout);
                end
                nout++;
            end
            if (in_valid && in_ready) acc++;
            tick();
        end
        n_checks++;
        if (nout != 6) begin
            n_errors++;
            $display("FAIL bp_delivered got=%0d want=6", nout);
        end
    endtask

    task automatic test_bubble();
        for (int c = 0; c < 8; c++) begin
            out_ready = 1'b0;
            in_valid  = (c % 2 == 0);
            in_data   = WIDTH'(8'hA0 + c / 2);
            #1;
            if (in_valid) begin
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_errors++;
                    $display("FAIL bubble_in_ready c=%0d got=%b want=1", c, in_ready);
                end
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (count !== CW'(4) || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL bubble_full count=%0d out_valid=%b in_ready=%b want=4/1/0",
                     count, out_valid, in_ready);
        end
        tick();
        for (int r = 0; r < 5; r++) begin
            out_ready = 1'b1;
            #1;
            n_checks++;
            if (out_valid !== (r < 4)) begin
                n_errors++;
                $display("FAIL bubble_out_valid r=%0d got=%b want=%b", r, out_valid, r < 4);
            end
            if (r < 4) begin
                n_checks++;
                if (out_data !== WIDTH'(8'hA0 + r)) begin
                    n_errors++;
                    $display("FAIL bubble_out_data r=%0d got=%h want=%h", r, out_data, 8'hA0 + r);
                end
            end
            tick();
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 3; c++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = WIDTH'(8'h50 + c);
            #1;
            tick();
        end
        flush   = 1'b1;
        in_data = 8'hEE;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_in_ready got=%b want=0", in_ready);
        end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (count !== 0 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_clear count=%0d out_valid=%b want=0/0", count, out_valid);
        end
        for (int r = 0; r < DEPTH + 2; r++) begin
            out_ready = 1'b1;
            #1;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL flush_leak r=%0d out_valid=%b data=%h want=0", r, out_valid, out_data);
            end
            tick();
        end
    endtask

    task automatic test_reset_stall();
        bit exp_v;
        for (int c = 0; c < 4; c++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = WIDTH'(8'h60 + c);
            #1;
            tick();
        end
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (count !== CW'(4) || out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL rststall_full count=%0d out_valid=%b want=4/1", count, out_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (count !== 0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
            n_errors++;
            $display("FAIL rststall_clear count=%0d out_valid=%b data=%h want=0/0/00",
                     count, out_valid, out_data);
        end
        for (int r = 0; r < 7; r++) begin
            out_ready = 1'b1;
            in_valid  = (r < 2);
            in_data   = WIDTH'(8'h30 + r);
            #1;
            exp_v = (r == 4) || (r == 5);
            n_checks++;
            if (out_valid !== exp_v) begin
                n_errors++;
                $display("FAIL rststall_out_valid r=%0d got=%b want=%b", r, out_valid, exp_v);
            end
            if (exp_v) begin
                n_checks++;
                if (out_data !== WIDTH'(8'h30 + r - 4)) begin
                    n_errors++;
                    $display("FAIL rststall_out_data r=%0d got=%h want=%h", r, out_data, 8'h30 + r - 4);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        bit exp_rdy;
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 149) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = WIDTH'($urandom);
            // Alternate phases of heavy and light backpressure to reach full and empty.
            out_ready = ((c / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = m_in_ready(flush, out_ready);
            n_checks++;
            if (in_ready !== exp_rdy) begin
                n_errors++;
                $display("FAIL rand_in_ready c=%0d got=%b want=%b", c, in_ready, exp_rdy);
            end
            n_checks++;
            if (out_valid !== m_out_valid()) begin
                n_errors++;
                $display("FAIL rand_out_valid c=%0d got=%b want=%b", c, out_valid, m_out_valid());
            end
            n_checks++;
            if (out_data !== m_last) begin
                n_errors++;
                $display("FAIL rand_out_data c=%0d got=%h want=%h", c, out_data, m_last);
            end
            n_checks++;
            if (count !== CW'(mq_data.size())) begin
                n_errors++;
                $display("FAIL rand_count c=%0d got=%0d want=%0d", c, count, mq_data.size());
            end
            tick();
        end
        rst   = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        #1;
        tick();
        tick();
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble();
        test_flush();
        test_reset_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/elastic_pipe.md
Name: elastic_pipe

Overview:
- Parametrised multi-bit, multi-stage successor to the single-bit posedge DFF. Registers a WIDTH-bit word through DEPTH register stages.
- Each stage carries a valid bit. A valid/ready handshake on both sides gives per-stage backpressure and bubble collapsing.
- Used between the game's random-number source, compare logic and display path, where consumers stall.

Parameters:
- WIDTH, 8: data word width in bits; must be at least 1.
- DEPTH, 4: number of register stages, and the fixed latency when unstalled; must be at least 1.
- CW, $clog2(DEPTH+1): width of the occupancy count; derived, never overridden.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous active-high reset.
- flush  input  1  synchronous clear of all in-flight words.
- in_valid  input  1  upstream presents a word.
- in_data  input  WIDTH  upstream word.
- in_ready  output  1  pipe accepts a word this cycle.
- out_valid  output  1  last stage holds a word.
- out_data  output  WIDTH  last-stage word.
- out_ready  input  1  downstream takes the word this cycle.
- count  output  CW  number of valid stages.

Behaviour:
- Stages and flow:
  - Stages are numbered 0 (input side) to DEPTH-1 (output side).
  - Each stage holds v[i] and d[i]. out_valid = v[DEPTH-1]; out_data = d[DEPTH-1].
  - Stage i advance condition: adv[i] = !v[i] || rdy[i+1], where rdy[DEPTH] = out_ready and rdy[i] = adv[i].
  - in_ready = adv[0] && !flush. This is a combinational path from out_ready; no skid buffering.
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
  - Stage update on a clock edge, when adv[i] is 1:
    - Stage 0 loads v[0] <= in_valid && in_ready. Stage i>0 loads v[i] <= v[i-1].
    - d[i] is written only when the incoming valid is 1. Otherwise d[i] holds its old value, so out_data holds its last value when out_valid=0.
  - When adv[i] is 0, stage i holds.
- Latency and throughput:
  - A word accepted at edge t into an empty, unstalled pipe gives out_valid=1 after edge t+DEPTH-1. That is DEPTH cycles, including the input register.
  - Throughput is 1 word per cycle while out_ready=1.
- Bubble collapsing: while out_ready=0, empty stages keep advancing. Gaps in the input stream are compressed until all DEPTH stages are valid.
- Full: count==DEPTH. Then in_ready = out_ready.
  - With full and out_ready=1, input and output transfer on the same cycle and count stays DEPTH.
- Empty: count==0, out_valid=0, in_ready=1 (unless flush=1).
- count:
  - Registered. Updates as +1 on input-only transfer, -1 on output-only transfer, unchanged on both or neither.
  - Must always equal the number of set v[i]. Never exceeds DEPTH and never wraps.
- Order and integrity: words leave in acceptance order. No drop or duplication except by flush or rst.
- flush:
  - Clears all v[i] and count to 0 on the next edge; d[i] are unchanged.
  - in_ready=0 during the flush cycle, so no input is accepted.
  - out_valid still reflects the pre-flush state during that cycle. A downstream taking the word then is legal, and the word is considered delivered.
- rst:
  - Priority over flush and all transfers.
  - Next edge: all v[i]=0, all d[i]=0, count=0. Hence out_valid=0 and out_data=0.
  - in_ready follows the combinational rule: it is 1 after reset while rst and flush are low.
  - Mid-operation reset discards all words with no partial outputs.
- out_ready while out_valid=0 has no effect. in_data is ignored when in_valid=0.

Test Plan:
- Reset (WIDTH=8, DEPTH=4): assert rst for 2 cycles after random traffic -> out_valid=0, out_data=0x00, count=0; in_ready=1 once rst drops.
- Streaming: out_ready=1, push 0x01..0x08 on consecutive cycles -> 0x01 appears with out_valid after 4 cycles, then one word per cycle in order; count holds 4 during the stream; no gaps.
- Backpressure: out_ready=0, in_valid=1 with 0x10..0x15 -> exactly 0x10..0x13 accepted; in_ready=0 after the 4th; count=4. Raise out_ready -> 0x10,0x11,0x12,0x13,0x14,0x15 in order; same-cycle push and pop at full keeps count=4.
- Bubble collapse: out_ready=0, in_valid alternating 1/0 with 0xA0..0xA3 -> after the last push count=4 and all four stages valid; release -> 0xA0..0xA3 on consecutive cycles.
- Flush mid-flight: 3 words in, then flush=1 with in_valid=1 and data 0xEE -> in_ready=0 that cycle; next cycle count=0, out_valid=0; 0xEE never emerges.
- Reset during stall: pipe full, out_ready=0, pulse rst -> next cycle count=0, out_valid=0; new words 0x30,0x31 then emerge with DEPTH latency and no stale data.
